safe_planning_multi_obs: RTL and testbench

//  Parametrised successor of the single-obstacle safe-planning plant: robot + N_OBS obstacles on a 3K x 3K grid.

---
 rtl/planning_pkg.sv | 34 +++
 rtl/planning_obstacle.sv | 69 ++++++
 rtl/safe_planning_multi_obs.sv | 153 +++++++++++++++
 tb/tb_safe_planning_multi_obs.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/planning_pkg.sv
// Shared definitions for the multi-obstacle safe-planning plant.
// Holds the phase encoding, the bit positions of a 4-bit move request
// {right,left,down,up}, and the wall test used by both the robot and the
// obstacles so that both obey exactly the same geometry.
// No ports (package).
package planning_pkg;

    typedef enum logic [2:0] {
        FIRST,
        INIT,
        RUN,
        ERROR,
        GOAL
    } phase_t;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    // Wall A separates x=K-1|K for rows y<2K, wall B separates x=2K-1|2K
    // for rows y>=2K. A horizontal step from (x,y) is blocked when it would
    // cross one of them; y is the row before the move.
    function automatic logic wall_blocks(input int x, input int y,
                                         input logic dir_right, input int k);
        logic blk;
        if (dir_right)
            blk = ((x == k - 1) && (y < 2 * k)) || ((x == 2 * k - 1) && (y >= 2 * k));
        else
            blk = ((x == k) && (y < 2 * k)) || ((x == 2 * k) && (y >= 2 * k));
        return blk;
    endfunction

endpackage

// File: rtl/planning_obstacle.sv
// One obstacle of the safe-planning plant.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (position -> (0,0))
//   load_i        load the start position (INIT_X, INIT_Y) this cycle
//   live_i        plant is in a live phase; moves are only taken then
//   move_i        {right,left,down,up} requests from the environment
//   rt_o          real-time event: live and any move bit set
//   x_o, y_o      registered position
// Vertical and horizontal steps may both happen in one cycle. Up wins over
// down, left wins over right. Steps clamp at the grid border and a
// horizontal step is dropped if it would cross a wall.
module planning_obstacle
    import planning_pkg::*;
#(
    parameter int K      = 2,
    parameter int W      = 4,
    parameter int INIT_X = 0,
    parameter int INIT_Y = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         live_i,
    input  logic [3:0]   move_i,
    output logic         rt_o,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o
);

    localparam logic [W-1:0] MAXC = W'(3 * K - 1);

    logic [W-1:0] x_q, y_q, x_d, y_d;

    assign rt_o = live_i & (|move_i);
    assign x_o  = x_q;
    assign y_o  = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (move_i[DIR_UP]) begin
            if (y_q != '0) y_d = y_q - W'(1);
        end else if (move_i[DIR_DOWN]) begin
            if (y_q != MAXC) y_d = y_q + W'(1);
        end
        // Wall test uses the row before this cycle's vertical step.
        if (move_i[DIR_LEFT]) begin
            if ((x_q != '0) && !wall_blocks(int'(x_q), int'(y_q), 1'b0, K))
                x_d = x_q - W'(1);
        end else if (move_i[DIR_RIGHT]) begin
            if ((x_q != MAXC) && !wall_blocks(int'(x_q), int'(y_q), 1'b1, K))
                x_d = x_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (load_i) begin
            x_q <= W'(INIT_X);
            y_q <= W'(INIT_Y);
        end else if (live_i) begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/safe_planning_multi_obs.sv
// Safe-planning plant: one robot and N_OBS obstacles on a 3K x 3K grid.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   end_init                 environment ends INIT, robot may start
//   move_robot               environment grants the robot a move
//   move_obs[4i+3:4i]        obstacle i {right,left,down,up}
//   controllable_*           robot direction request (down>up>left>right)
//   error, goal              sticky collision / goal flags (registered)
//   _rt_robot, _rt_obs       real-time move events this cycle
// y grows with "down"; "up" decreases y. The phase FSM, robot position,
// fairness flag (excl) and the error/goal latches live here; the
// obstacles are instantiated per index.
module safe_planning_multi_obs
    import planning_pkg::*;
#(
    parameter int K      = 2,
    parameter int N_OBS  = 2,
    parameter int W      = 4,
    parameter int GOAL_X = 5,
    parameter int GOAL_Y = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               end_init,
    input  logic               move_robot,
    input  logic [4*N_OBS-1:0] move_obs,
    input  logic               controllable_up,
    input  logic               controllable_down,
    input  logic               controllable_left,
    input  logic               controllable_right,
    output logic               error,
    output logic               goal,
    output logic               _rt_robot,
    output logic [N_OBS-1:0]   _rt_obs
);

    localparam int SW = $clog2(N_OBS + 2);
    localparam logic [W-1:0] MAXC = W'(3 * K - 1);

    phase_t       phase_q;
    logic [W-1:0] robotX_q, robotY_q, robotX_d, robotY_d;
    logic         excl_q, error_q, goal_q;
    logic         live, loadObs, curExcl, coll, errSet, goalSet;
    logic [SW-1:0] rtCount;
    logic [W-1:0] obsX [N_OBS];
    logic [W-1:0] obsY [N_OBS];
    logic [N_OBS-1:0] hit;

    assign live      = (phase_q == INIT) || (phase_q == RUN);
    assign loadObs   = (phase_q == FIRST);
    assign _rt_robot = (phase_q == RUN) & move_robot;
    assign error     = error_q;
    assign goal      = goal_q;

    for (genvar i = 0; i < N_OBS; i++) begin : genObs
        // Start column saturates at the right border; start row likewise.
        localparam int IX = (2 + i > 3 * K - 1) ? 3 * K - 1 : 2 + i;
        localparam int IY = (i > 3 * K - 1) ? 3 * K - 1 : i;
        planning_obstacle #(
            .K(K), .W(W), .INIT_X(IX), .INIT_Y(IY)
        ) uObs (
            .clk    (clk),
            .rst    (rst),
            .load_i (loadObs),
            .live_i (live),
            .move_i (move_obs[4*i +: 4]),
            .rt_o   (_rt_obs[i]),
            .x_o    (obsX[i]),
            .y_o    (obsY[i])
        );
        assign hit[i] = (obsX[i] == robotX_q) && (obsY[i] == robotY_q);
    end

    assign coll = |hit;

    // The environment is fair only while at most one real-time event fires.
    always_comb begin
        rtCount = SW'(_rt_robot);
        for (int i = 0; i < N_OBS; i++)
            rtCount = rtCount + SW'(_rt_obs[i]);
    end

    assign curExcl = (rtCount <= SW'(1));
    assign errSet  = excl_q & curExcl & coll;
    assign goalSet = excl_q & curExcl & ~coll &
                     (robotX_q == W'(GOAL_X)) & (robotY_q == W'(GOAL_Y));

    // Robot takes exactly one step in the highest-priority requested
    // direction; a clamped or walled step is simply lost.
    always_comb begin
        robotX_d = robotX_q;
        robotY_d = robotY_q;
        if (_rt_robot) begin
            if (controllable_down) begin
                if (robotY_q != MAXC) robotY_d = robotY_q + W'(1);
            end else if (controllable_up) begin
                if (robotY_q != '0) robotY_d = robotY_q - W'(1);
            end else if (controllable_left) begin
                if ((robotX_q != '0) &&
                    !wall_blocks(int'(robotX_q), int'(robotY_q), 1'b0, K))
                    robotX_d = robotX_q - W'(1);
            end else if (controllable_right) begin
                if ((robotX_q != MAXC) &&
                    !wall_blocks(int'(robotX_q), int'(robotY_q), 1'b1, K))
                    robotX_d = robotX_q + W'(1);
            end
        end
    end

    // Phase FSM with the sticky flags. A collision detected during INIT also
    // ends the run in ERROR; error wins over goal in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= FIRST;
            robotX_q <= '0;
            robotY_q <= '0;
            excl_q   <= 1'b0;
            error_q  <= 1'b0;
            goal_q   <= 1'b0;
        end else begin
            unique case (phase_q)
                FIRST: begin
                    phase_q <= INIT;
                    excl_q  <= 1'b1;
                end
                INIT: begin
                    excl_q <= excl_q & curExcl;
                    if (errSet) begin
                        error_q <= 1'b1;
                        phase_q <= ERROR;
                    end else if (end_init) begin
                        phase_q <= RUN;
                    end
                end
                RUN: begin
                    excl_q   <= excl_q & curExcl;
                    robotX_q <= robotX_d;
                    robotY_q <= robotY_d;
                    if (errSet) begin
                        error_q <= 1'b1;
                        phase_q <= ERROR;
                    end else if (goalSet) begin
                        goal_q  <= 1'b1;
                        phase_q <= GOAL;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_safe_planning_multi_obs.sv
// Directed bench for safe_planning_multi_obs at K=2, N_OBS=2, goal (5,5).
// Internal positions/phase are observed hierarchically; every expected
// value below is hand-derived from the grid geometry.
module tb_safe_planning_multi_obs;
    import planning_pkg::*;

    localparam logic [3:0] NONE  = 4'b0000;
    localparam logic [3:0] UP    = 4'b0001;
    localparam logic [3:0] DOWN  = 4'b0010;
    localparam logic [3:0] LEFT  = 4'b0100;
    localparam logic [3:0] RIGHT = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       end_init = 1'b0;
    logic       move_robot = 1'b0;
    logic [7:0] move_obs = 8'h00;
    logic       controllable_up = 1'b0;
    logic       controllable_down = 1'b0;
    logic       controllable_left = 1'b0;
    logic       controllable_right = 1'b0;
    logic       error, goal, rtRobot;
    logic [1:0] rtObs;

    int checkCount = 0;
    int errorCount = 0;

    safe_planning_multi_obs #(.K(2), .N_OBS(2), .W(4), .GOAL_X(5), .GOAL_Y(5)) dut (
        .clk                (clk),
        .rst                (rst),
        .end_init           (end_init),
        .move_robot         (move_robot),
        .move_obs           (move_obs),
        .controllable_up    (controllable_up),
        .controllable_down  (controllable_down),
        .controllable_left  (controllable_left),
        .controllable_right (controllable_right),
        .error              (error),
        .goal               (goal),
        ._rt_robot          (rtRobot),
        ._rt_obs            (rtObs)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic mr, input logic [3:0] rdir,
                                 input logic [7:0] mobs, input logic ei);
        move_robot = mr;
        {controllable_right, controllable_left, controllable_down, controllable_up} = rdir;
        move_obs = mobs;
        end_init = ei;
    endtask

    task automatic idle();
        applyStimulus(1'b0, NONE, 8'h00, 1'b0);
    endtask

    task automatic robotStep(input logic [3:0] d);
        applyStimulus(1'b1, d, 8'h00, 1'b0);
        tick();
        idle();
    endtask

    task automatic obsStep(input logic [7:0] m);
        applyStimulus(1'b0, NONE, m, 1'b0);
        tick();
        idle();
    endtask

    task automatic checkRobot(input string tag, input int x, input int y);
        checkOutput({tag, "_rx"}, 32'(dut.robotX_q), x);
        checkOutput({tag, "_ry"}, 32'(dut.robotY_q), y);
    endtask

    task automatic checkObs(input string tag, input int i, input int x, input int y);
        checkOutput({tag, "_ox"}, 32'(dut.obsX[i]), x);
        checkOutput({tag, "_oy"}, 32'(dut.obsY[i]), y);
    endtask

    task automatic checkPhase(input string tag, input phase_t p);
        checkOutput({tag, "_phase"}, 32'(dut.phase_q), 32'(p));
    endtask

    task automatic resetAndCheck(input string tag);
        idle();
        #2;
        rst = 1'b1;
        #1;
        checkOutput({tag, "_error"}, 32'(error), 0);
        checkOutput({tag, "_goal"}, 32'(goal), 0);
        checkOutput({tag, "_rtRobot"}, 32'(rtRobot), 0);
        checkOutput({tag, "_rtObs"}, 32'(rtObs), 0);
        checkRobot(tag, 0, 0);
        checkPhase(tag, FIRST);
        rst = 1'b0;
    endtask

    task automatic enterRun();
        applyStimulus(1'b0, NONE, 8'h00, 1'b1);
        tick();
        idle();
    endtask

    // Walks obstacle 0 from (2,0) around wall A to (1,0) while in INIT.
    task automatic obs0ToOneZero(input string tag);
        obsStep({4'b0000, LEFT});
        checkObs({tag, "_wallA"}, 0, 2, 0);
        for (int n = 0; n < 4; n++) obsStep({4'b0000, DOWN});
        obsStep({4'b0000, LEFT | UP});
        checkObs({tag, "_diag"}, 0, 1, 3);
        for (int n = 0; n < 3; n++) obsStep({4'b0000, UP});
        checkObs({tag, "_atOneZero"}, 0, 1, 0);
    endtask

    initial begin
        // Reset, INIT hold and walls for the robot, then a mid-RUN reset.
        resetAndCheck("rst0");
        tick();
        checkPhase("init0", INIT);
        checkObs("init0_obs0", 0, 2, 0);
        checkObs("init0_obs1", 1, 3, 1);
        applyStimulus(1'b1, RIGHT, 8'h00, 1'b0);
        #1;
        checkOutput("initRtRobot", 32'(rtRobot), 0);
        tick();
        checkRobot("initHold", 0, 0);
        checkPhase("initHold", INIT);
        idle();
        enterRun();
        checkPhase("run0", RUN);
        applyStimulus(1'b1, RIGHT, 8'h00, 1'b0);
        #1;
        checkOutput("runRtRobot", 32'(rtRobot), 1);
        tick();
        idle();
        checkRobot("right1", 1, 0);
        robotStep(RIGHT);
        checkRobot("wallA", 1, 0);
        for (int n = 0; n < 4; n++) robotStep(DOWN);
        checkRobot("down4", 1, 4);
        robotStep(RIGHT);
        checkRobot("passA", 2, 4);
        robotStep(RIGHT);
        robotStep(UP);
        checkRobot("at33", 3, 3);
        resetAndCheck("rstMid");

        // Goal run: obstacle clamp, then robot route to (5,5).
        tick();
        applyStimulus(1'b0, NONE, {UP, 4'b0000}, 1'b0);
        #1;
        checkOutput("rtObs1", 32'(rtObs), 2);
        tick();
        idle();
        obsStep({UP, 4'b0000});
        checkObs("clampTop", 1, 3, 0);
        enterRun();
        for (int n = 0; n < 4; n++) robotStep(DOWN);
        robotStep(RIGHT);
        robotStep(RIGHT);
        robotStep(RIGHT);
        robotStep(RIGHT);
        checkRobot("wallB", 3, 4);
        robotStep(UP);
        robotStep(RIGHT);
        robotStep(RIGHT);
        robotStep(DOWN);
        robotStep(DOWN);
        checkRobot("atGoal", 5, 5);
        checkOutput("goalPending", 32'(goal), 0);
        tick();
        checkOutput("goalSet", 32'(goal), 1);
        checkPhase("goal", GOAL);
        applyStimulus(1'b1, UP, 8'h11, 1'b0);
        #1;
        checkOutput("goalRtRobot", 32'(rtRobot), 0);
        checkOutput("goalRtObs", 32'(rtObs), 0);
        tick();
        idle();
        checkRobot("goalFrozen", 5, 5);
        checkOutput("goalNoError", 32'(error), 0);

        // Collision with the environment fair: error then ERROR phase.
        resetAndCheck("rst2");
        tick();
        obs0ToOneZero("coll");
        enterRun();
        applyStimulus(1'b0, NONE, {4'b0000, LEFT}, 1'b0);
        #1;
        checkOutput("collRtObs", 32'(rtObs), 1);
        tick();
        idle();
        checkObs("collPos", 0, 0, 0);
        checkOutput("collFlag", 32'(dut.coll), 1);
        checkOutput("collErrPending", 32'(error), 0);
        tick();
        checkOutput("collError", 32'(error), 1);
        checkPhase("collError", ERROR);
        tick();
        checkOutput("errorSticky", 32'(error), 1);

        // Same collision after a double real-time event: no error ever.
        resetAndCheck("rst3");
        tick();
        obs0ToOneZero("excl");
        enterRun();
        applyStimulus(1'b1, NONE, {RIGHT, 4'b0000}, 1'b0);
        tick();
        idle();
        checkOutput("exclLost", 32'(dut.excl_q), 0);
        checkObs("exclObs1", 1, 4, 1);
        obsStep({4'b0000, LEFT});
        for (int n = 0; n < 3; n++) tick();
        checkOutput("exclColl", 32'(dut.coll), 1);
        checkOutput("exclNoError", 32'(error), 0);
        checkOutput("exclNoGoal", 32'(goal), 0);
        checkPhase("exclRun", RUN);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
